// File: rtl/switch_block_prog.sv
// switch_block_prog: programmable three-sided (left/right/top) routing switch
// block. Route selects are shifted serially into a shadow register over the
// configuration chain and then committed atomically to the active register,
// which drives the routing muxes. cfg_dout chains the shadow MSB to the next tile.
//
// Optional build macro SB_OUTPUT_REG_EN: when defined, the routed outputs are
// registered (one cycle of latency). When undefined, the outputs are
// combinational from the active image and the inputs.
module switch_block_prog #(
  parameter int CHANNEL_ONEWAY_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNEL_ONEWAY_WIDTH-1:0] left_in,
  input  logic [CHANNEL_ONEWAY_WIDTH-1:0] right_in,
  input  logic [CHANNEL_ONEWAY_WIDTH-1:0] top_in,
  output logic [CHANNEL_ONEWAY_WIDTH-1:0] left_out,
  output logic [CHANNEL_ONEWAY_WIDTH-1:0] right_out,
  output logic [CHANNEL_ONEWAY_WIDTH-1:0] top_out,
  input  logic                            cfg_en,
  input  logic                            cfg_din,
  output logic                            cfg_dout,
  input  logic                            cfg_commit,
  output logic                            cfg_valid,
  output logic                            cfg_err
);

  localparam int unsigned W        = CHANNEL_ONEWAY_WIDTH;
  localparam int unsigned CFG_BITS = 6 * W;
  localparam int unsigned CNT_W    = $clog2(CFG_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_BITS + 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2,
    OVER    = 2'd3
  } state_t;

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  state_t              state;
  state_t              state_next;
  logic                commit_ok;

  logic [W-1:0] left_mux;
  logic [W-1:0] right_mux;
  logic [W-1:0] top_mux;

  // Twisted track index used for the A sources and the top-side B source.
  function automatic int unsigned twist(input int unsigned i);
    return (i < W - 1) ? (W - 2 - i) : (W - 1);
  endfunction

  // Two-bit select decode: 00 -> 0, 01 -> A, 10 -> B, 11 (reserved) -> 0.
  function automatic logic pick(input logic [1:0] sel, input logic a, input logic b);
    logic r;
    case (sel)
      2'b01:   r = a;
      2'b10:   r = b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Classify a bit count into the control state it implies.
  function automatic state_t state_of(input logic [CNT_W-1:0] c);
    state_t s;
    if (c == '0)
      s = EMPTY;
    else if (c < CNT_FULL)
      s = LOADING;
    else if (c == CNT_FULL)
      s = FULL;
    else
      s = OVER;
    return s;
  endfunction

  // Next bit count: any commit attempt restarts the count; a commit coinciding
  // with a shift restarts at one so that shift is still counted.
  always_comb begin
    count_next = count;
    commit_ok  = cfg_commit && !cfg_en && (state == FULL);
    if (cfg_commit)
      count_next = cfg_en ? CNT_ONE : '0;
    else if (cfg_en && (count != CNT_OVER))
      count_next = count + 1'b1;
    state_next = state_of(count_next);
  end

  // Serial configuration shift register, first bit lands in the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (cfg_en)
      shadow <= {shadow[CFG_BITS-2:0], cfg_din};
  end

  assign cfg_dout = shadow[CFG_BITS-1];

  // Control FSM: tracks the bit count and accepts or rejects commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      state     <= EMPTY;
      active    <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      count <= count_next;
      state <= state_next;
      if (cfg_commit) begin
        if (commit_ok) begin
          active    <= shadow;
          cfg_valid <= 1'b1;
          cfg_err   <= 1'b0;
        end else begin
          cfg_err   <= 1'b1;
        end
      end
    end
  end

  // Routing muxes driven by the active select image.
  always_comb begin
    left_mux  = '0;
    right_mux = '0;
    top_mux   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      left_mux[i]  = pick(active[2*i +: 2],
                          top_in[twist(i)], right_in[i]);
      right_mux[i] = pick(active[2*(W+i) +: 2],
                          top_in[twist(i)], left_in[i]);
      top_mux[i]   = pick(active[2*(2*W+i) +: 2],
                          left_in[twist(i)], right_in[twist(i)]);
    end
  end

`ifdef SB_OUTPUT_REG_EN
  // Registered routing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_out  <= '0;
      right_out <= '0;
      top_out   <= '0;
    end else begin
      left_out  <= left_mux;
      right_out <= right_mux;
      top_out   <= top_mux;
    end
  end
`else
  assign left_out  = left_mux;
  assign right_out = right_mux;
  assign top_out   = top_mux;
`endif

endmodule

// File: tb/tb_switch_block_prog.sv
// Self-checking bench for switch_block_prog (W = 4, 24 config bits).
// Expected routing is produced by a bench-side model and queued when stimulus
// is driven; each scenario task pops and compares once the DUT has settled.
module tb_switch_block_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] left_in, right_in, top_in;
  logic [3:0] left_out, right_out, top_out;
  logic       cfg_en, cfg_din, cfg_dout, cfg_commit, cfg_valid, cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench model of configuration state.
  logic [23:0] m_shadow;
  logic [23:0] m_active;
  logic        m_valid;
  logic        m_err;
  int          m_cnt;

  logic [11:0] exp_q[$];
  logic        dout_q[$];

  switch_block_prog #(.CHANNEL_ONEWAY_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .left_in(left_in), .right_in(right_in), .top_in(top_in),
    .left_out(left_out), .right_out(right_out), .top_out(top_out),
    .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .cfg_commit(cfg_commit), .cfg_valid(cfg_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference routing: returns {left_out, right_out, top_out}.
  function automatic logic [11:0] expect_out(input logic [23:0] act,
                                             input logic [3:0] l,
                                             input logic [3:0] r,
                                             input logic [3:0] t);
    logic [3:0] lo, ro, to;
    logic [1:0] sl, sr, st;
    int ti;
    lo = '0; ro = '0; to = '0;
    for (int i = 0; i < 4; i++) begin
      ti = (i == 3) ? 3 : 2 - i;
      sl = act[2*i +: 2];
      sr = act[2*(4+i) +: 2];
      st = act[2*(8+i) +: 2];
      lo[i] = (sl == 2'b01) ? t[ti] : (sl == 2'b10) ? r[i]  : 1'b0;
      ro[i] = (sr == 2'b01) ? t[ti] : (sr == 2'b10) ? l[i]  : 1'b0;
      to[i] = (st == 2'b01) ? l[ti] : (st == 2'b10) ? r[ti] : 1'b0;
    end
    return {lo, ro, to};
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  // Shift data[n-1:0] MSB-first; starts and ends just after a falling edge.
  task automatic shift_bits(input logic [31:0] data, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      cfg_en = 1'b1; cfg_din = data[k];
      @(posedge clk);
      m_shadow = {m_shadow[22:0], data[k]};
      if (m_cnt < 25) m_cnt++;
      @(negedge clk);
    end
    cfg_en = 1'b0; cfg_din = 1'b0;
  endtask

  task automatic do_commit(input logic with_en, input logic din);
    cfg_commit = 1'b1; cfg_en = with_en; cfg_din = din;
    @(posedge clk);
    if (with_en) begin
      m_shadow = {m_shadow[22:0], din};
      m_err = 1'b1; m_cnt = 1;
    end else if (m_cnt == 24) begin
      m_active = m_shadow; m_valid = 1'b1; m_err = 1'b0; m_cnt = 0;
    end else begin
      m_err = 1'b1; m_cnt = 0;
    end
    @(negedge clk);
    cfg_commit = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0;
  endtask

  // Drive inputs and queue the expected routing; one edge covers registered outputs.
  task automatic drive_io(input logic [3:0] l, input logic [3:0] r, input logic [3:0] t);
    left_in = l; right_in = r; top_in = t;
    exp_q.push_back(expect_out(m_active, l, r, t));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst_n = 1'b0;
    left_in = 4'($urandom); right_in = 4'($urandom); top_in = 4'($urandom);
    model_reset();
    #1;
    got = {left_out, right_out, top_out};
    n_checks++;
    if (got !== 12'h000) begin n_fail++; $display("FAIL reset_outs: got %h expected 000", got); end
    n_checks++;
    if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", cfg_valid); end
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
    n_checks++;
    if (cfg_dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b expected 0", cfg_dout); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_route_a();
    logic [11:0] got, exp;
    shift_bits(32'h005500, 24);
    do_commit(1'b0, 1'b0);
    n_checks++;
    if (cfg_valid !== 1'b1) begin n_fail++; $display("FAIL route_a_valid: got %b expected 1", cfg_valid); end
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL route_a_err: got %b expected 0", cfg_err); end
    drive_io(4'hF, 4'hF, 4'b0001);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'h040) begin n_fail++; $display("FAIL route_a_top0001: got %h expected %h", got, exp); end
    drive_io(4'h0, 4'h0, 4'b1000);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'h080) begin n_fail++; $display("FAIL route_a_top1000: got %h expected %h", got, exp); end
  endtask

  task automatic test_select_b_reserved();
    logic [11:0] got, exp;
    shift_bits(32'h0000AA, 24);
    do_commit(1'b0, 1'b0);
    drive_io(4'h0, 4'b1010, 4'h0);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'hA00) begin n_fail++; $display("FAIL select_b: got %h expected %h", got, exp); end
    shift_bits(32'h0000FF, 24);
    do_commit(1'b0, 1'b0);
    drive_io(4'hF, 4'b1010, 4'hF);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'h000) begin n_fail++; $display("FAIL reserved_sel: got %h expected %h", got, exp); end
  endtask

  task automatic test_short_image();
    logic [11:0] got, exp;
    shift_bits(32'h0000AA, 24);
    do_commit(1'b0, 1'b0);
    shift_bits(32'h005500, 23);
    do_commit(1'b0, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b expected 1", cfg_err); end
    n_checks++;
    if (cfg_valid !== m_valid) begin n_fail++; $display("FAIL short_valid: got %b expected %b", cfg_valid, m_valid); end
    drive_io(4'h0, 4'b1010, 4'h0);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'hA00) begin n_fail++; $display("FAIL short_retained: got %h expected %h", got, exp); end
    shift_bits(32'h005500, 24);
    do_commit(1'b0, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL short_recover_err: got %b expected 0", cfg_err); end
  endtask

  task automatic test_overflow();
    logic [11:0] got, exp;
    shift_bits(32'h00AA00, 25);
    do_commit(1'b0, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL over_err: got %b expected 1", cfg_err); end
    n_checks++;
    if (cfg_valid !== 1'b1) begin n_fail++; $display("FAIL over_valid: got %b expected 1", cfg_valid); end
    drive_io(4'h0, 4'h0, 4'b0001);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'h040) begin n_fail++; $display("FAIL over_retained: got %h expected %h", got, exp); end
  endtask

  task automatic test_simultaneous();
    logic [11:0] got, exp;
    shift_bits(32'h0000AA, 24);
    do_commit(1'b0, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL simul_pre_err: got %b expected 0", cfg_err); end
    shift_bits(32'h005500, 24);
    do_commit(1'b1, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL simul_err: got %b expected 1", cfg_err); end
    drive_io(4'h0, 4'b1010, 4'b0001);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'hA00) begin n_fail++; $display("FAIL simul_retained: got %h expected %h", got, exp); end
    // Count restarted at 1: 23 more bits complete a full image.
    shift_bits(32'h005500, 23);
    do_commit(1'b0, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b0 || cfg_valid !== 1'b1) begin
      n_fail++; $display("FAIL simul_count1: got err=%b valid=%b expected err=0 valid=1", cfg_err, cfg_valid);
    end
    drive_io(4'h0, 4'h0, 4'b0001);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'h040) begin n_fail++; $display("FAIL simul_route: got %h expected %h", got, exp); end
  endtask

  task automatic test_chain();
    logic [23:0] pat;
    logic        e;
    pat = 24'hA5A5A5;
    shift_bits({8'h00, pat}, 24);
    for (int k = 23; k >= 0; k--) dout_q.push_back(pat[k]);
    for (int k = 0; k < 24; k++) begin
      e = dout_q.pop_front();
      n_checks++;
      if (cfg_dout !== e) begin n_fail++; $display("FAIL chain_dout[%0d]: got %b expected %b", k, cfg_dout, e); end
      cfg_en = 1'b1; cfg_din = 1'b0;
      @(posedge clk);
      m_shadow = {m_shadow[22:0], 1'b0};
      if (m_cnt < 25) m_cnt++;
      @(negedge clk);
    end
    cfg_en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [11:0] got, exp;
    drive_io(4'h0, 4'h0, 4'b1000);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'h080) begin n_fail++; $display("FAIL areset_pre_route: got %h expected %h", got, exp); end
    do_commit(1'b0, 1'b0);
    shift_bits(32'h1FF, 9);
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_dout !== m_shadow[23]) begin
      n_fail++; $display("FAIL areset_pre_flags: got err=%b dout=%b expected err=1 dout=%b", cfg_err, cfg_dout, m_shadow[23]);
    end
    cfg_en = 1'b1; cfg_din = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    got = {left_out, right_out, top_out};
    n_checks++;
    if (got !== 12'h000) begin n_fail++; $display("FAIL areset_outs: got %h expected 000", got); end
    n_checks++;
    if (cfg_valid !== 1'b0 || cfg_err !== 1'b0 || cfg_dout !== 1'b0) begin
      n_fail++; $display("FAIL areset_flags: got valid=%b err=%b dout=%b expected 0 0 0", cfg_valid, cfg_err, cfg_dout);
    end
    cfg_en = 1'b0; cfg_din = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // A full 24-bit image commits only if the bit count was cleared by reset.
    shift_bits(32'h0000AA, 24);
    do_commit(1'b0, 1'b0);
    n_checks++;
    if (cfg_valid !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL areset_count: got valid=%b err=%b expected valid=1 err=0", cfg_valid, cfg_err);
    end
    drive_io(4'h0, 4'b1010, 4'h0);
    got = {left_out, right_out, top_out}; exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== 12'hA00) begin n_fail++; $display("FAIL areset_route: got %h expected %h", got, exp); end
  endtask

  initial begin
    cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    test_reset();
    test_route_a();
    test_select_b_reserved();
    test_short_image();
    test_overflow();
    test_simultaneous();
    test_chain();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
